led_ctrl: RTL and testbench

Parametrised multi-channel LED driver for the EBAZ4205 PL. It takes a per-channel mode word from the AXI GPIO register and drives board LEDs as off, on, blinking or PWM-dimmed. A shared millisecond prescaler and blink phase keep all blinking channels in lockstep. It supersedes the fixed two-LED blinker and sits between the PS GPIO output and the LED pins.

---
 rtl/led_ctrl_pkg.sv | 15 +
 rtl/led_tick_gen.sv | 41 ++++
 rtl/led_ctrl.sv | 98 +++++++++
 tb/tb_led_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED driver: per-channel mode encodings and the
// prescaler width helper used by led_tick_gen and later timer blocks.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PWM   = 2'b11;

    // Width of a counter that holds 0..d-1.
    function automatic int unsigned div_width(input int unsigned d);
        return (d < 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous restart; clears the count and suppresses tick
//   tick        registered strobe, high for one cycle when the count wraps
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = div_width(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == LAST);

    // Count 0..DIV-1; clr wins over the wrap in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED driver: off / on / blink / PWM per channel, with a shared
// tick, blink phase and PWM counter so all channels stay in lockstep.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   mode        2 bits per channel (off, on, blink, PWM)
//   duty        PWM_BITS per channel; on while pwm_cnt < duty
//   half_ms     blink half-period in ticks (0 behaves as 1)
//   sync_clr    re-phase strobe: clears all shared counters
//   led_out     registered LED drive, 1 = lit
//   tick        registered tick strobe for other blocks
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned N_CH     = 2,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*N_CH-1:0]          mode,
    input  logic [PWM_BITS*N_CH-1:0]   duty,
    input  logic [15:0]                half_ms,
    input  logic                       sync_clr,
    output logic [N_CH-1:0]            led_out,
    output logic                       tick
);

    logic [15:0]         phase_cnt;
    logic [15:0]         half_m1;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_CH-1:0]     led_next;

    led_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync_clr),
        .tick  (tick)
    );

    assign half_m1 = (half_ms == 16'd0) ? 16'd0 : half_ms - 16'd1;

    // Blink phase; >= compare lets a lowered half_ms take effect on the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt   <= 16'd0;
            blink_phase <= 1'b0;
        end else if (sync_clr) begin
            phase_cnt   <= 16'd0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (phase_cnt >= half_m1) begin
                phase_cnt   <= 16'd0;
                blink_phase <= ~blink_phase;
            end else begin
                phase_cnt <= phase_cnt + 16'd1;
            end
        end
    end

    // Free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (sync_clr) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Per-channel output select.
    always_comb begin
        led_next = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            case (mode[2*i +: 2])
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_BLINK: led_next[i] = blink_phase;
                MODE_PWM:   led_next[i] = (pwm_cnt < duty[PWM_BITS*i +: PWM_BITS]);
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else begin
            led_out <= led_next;
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with D=10, N_CH=4, PWM_BITS=4.
module tb_led_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mode;
    logic [15:0] duty;
    logic [15:0] half_ms;
    logic        sync_clr;
    logic [3:0]  led_out;
    logic        tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    led_ctrl #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .N_CH     (4),
        .PWM_BITS (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .duty     (duty),
        .half_ms  (half_ms),
        .sync_clr (sync_clr),
        .led_out  (led_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after edge e (edges counted from the last reset release).
    task automatic go(input int e);
        repeat (e - cyc) @(posedge clk);
        cyc = e;
        #1;
    endtask

    initial begin
        int c0, c2, c3;
        logic [3:0] e;
        rst_n    = 1'b0;
        mode     = 8'b00_01_10_00;
        duty     = 16'h0000;
        half_ms  = 16'd3;
        sync_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        cyc   = 0;

        // Static modes and first blink with half_ms=3
        go(1);   check("static_e1", 32'(led_out), 32'b0100);
        go(9);   check("tick_e9", 32'(tick), 32'h0);
        go(10);  check("tick_e10", 32'(tick), 32'h1);
        go(11);  check("tick_e11", 32'(tick), 32'h0);
        go(20);  check("tick_e20", 32'(tick), 32'h1);
        go(31);  check("blink_e31", 32'(led_out), 32'b0100);
        go(32);  check("blink_e32", 32'(led_out), 32'b0110);
        go(61);  check("blink_e61", 32'(led_out[1]), 32'h1);
        go(62);  check("blink_e62", 32'(led_out[1]), 32'h0);
        go(91);  check("blink_e91", 32'(led_out[1]), 32'h0);
        go(92);  check("blink_e92", 32'(led_out[1]), 32'h1);

        // sync_clr mid-blink, coinciding with a would-be tick
        go(99);  check("pre_clr", 32'(led_out[1]), 32'h1);
        sync_clr = 1'b1;
        go(100); check("clr_tick_supp", 32'(tick), 32'h0);
        sync_clr = 1'b0;
        go(101); check("clr_led", 32'(led_out[1]), 32'h0);
        go(109); check("clr_tick9", 32'(tick), 32'h0);
        go(110); check("clr_tick10", 32'(tick), 32'h1);
        go(131); check("clr_blink31", 32'(led_out[1]), 32'h0);
        go(132); check("clr_blink32", 32'(led_out[1]), 32'h1);

        // One-clock mode latency, then PWM duty 0 / 15 / 5
        mode = 8'b00_01_10_01;
        go(133); check("mode_lat", 32'(led_out[0]), 32'h1);
        mode = 8'b11_11_10_11;
        duty = {4'd5, 4'd15, 4'd0, 4'd0};
        c0 = 0; c2 = 0; c3 = 0;
        for (int k = 135; k <= 150; k++) begin
            go(k);
            c0 += int'(led_out[0]);
            c2 += int'(led_out[2]);
            c3 += int'(led_out[3]);
        end
        check("pwm_d0", 32'(c0), 32'd0);
        check("pwm_d15", 32'(c2), 32'd15);
        check("pwm_d5", 32'(c3), 32'd5);

        // half_ms 100 -> 2 with phase_cnt=50: toggle on the next tick
        half_ms  = 16'd100;
        sync_clr = 1'b1;
        go(151);
        sync_clr = 1'b0;
        go(656);
        half_ms = 16'd2;
        go(662); check("lower_e511", 32'(led_out[1]), 32'h0);
        go(663); check("lower_e512", 32'(led_out[1]), 32'h1);
        go(682); check("lower_e531", 32'(led_out[1]), 32'h1);
        go(683); check("lower_e532", 32'(led_out[1]), 32'h0);

        // half_ms 0 behaves as 1: toggle every tick
        half_ms  = 16'd0;
        sync_clr = 1'b1;
        go(684);
        sync_clr = 1'b0;
        go(695); check("h0_e11", 32'(led_out[1]), 32'h0);
        go(696); check("h0_e12", 32'(led_out[1]), 32'h1);
        go(705); check("h0_e21", 32'(led_out[1]), 32'h1);
        go(706); check("h0_e22", 32'(led_out[1]), 32'h0);
        go(716); check("h0_e32", 32'(led_out[1]), 32'h1);

        // Asynchronous reset mid-PWM, then the post-release sequence
        go(720);
        #2 rst_n = 1'b0;
        #1;
        check("async_led", 32'(led_out), 32'h0);
        check("async_tick", 32'(tick), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 16; k++) begin
            go(k);
            e[0] = 1'b0;
            e[1] = (k >= 12);
            e[2] = (((k - 1) % 16) < 15);
            e[3] = (((k - 1) % 16) < 5);
            check($sformatf("post_rst_led%0d", k), 32'(led_out), 32'(e));
            check($sformatf("post_rst_tick%0d", k), 32'(tick), 32'(k == 10));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
